unidade_controle_multiciclo: RTL
================================

# unidade_controle_multiciclo

Multi-cycle control FSM for the MIPS-subset datapath. It is the producer side of the 4-bit ALU control interface. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable. It consumes the ALU `zero` flag for branches and a `memPronta` handshake from unified instruction/data memory.

## Interface
Parameters
- `LARGURA_ESTADO`, 4: width of state register and `estado` debug port.

Ports
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  6  IR[31:26]; stable from DECODIFICA until the next BUSCA.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU result == 0.
- `memPronta`  in  1  memory completes the current read/write this cycle.
- `controleUla`  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLT, 0101 NOR.
- `escrevePC`  out  1  PC load.
- `lerMem`, `escreveMem`  out  1 each  memory request (level, held until `memPronta`).
- `iouD`  out  1  memory address source: 0 PC, 1 ALUOut.
- `escreveIR`  out  1  IR load.
- `regDst`  out  1  0 rt, 1 rd.
- `memParaReg`  out  1  0 ALUOut, 1 MDR.
- `escreveReg`  out  1  register file write.
- `ulaFonteA`  out  1  0 PC, 1 A.
- `ulaFonteB`  out  2  00 B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `fontePC`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `excecao`  out  1  one-cycle pulse on an illegal opcode or funct.
- `estado`  out  4  current state code.

## Operation
- States (codes 0–12): BUSCA, DECODIFICA, END_MEM, LE_MEM, ESCREVE_LW, ESCREVE_MEM, EXECUTA_R, FIM_R, DESVIO, SALTO, EXECUTA_I, FIM_I, ILEGAL.
- Any output not listed for a state is 0.
- **BUSCA**
  - Outputs: `lerMem`=1, `iouD`=0, `ulaFonteA`=0, `ulaFonteB`=01, ADD, `fontePC`=00.
  - `escreveIR` and `escrevePC` = `memPronta`.
  - Stays in BUSCA until `memPronta`, then goes to DECODIFICA.
- **DECODIFICA**
  - Outputs: `ulaFonteA`=0, `ulaFonteB`=11, ADD (branch target precomputed into ALUOut).
  - Next state by opcode:
    - 0x00 → EXECUTA_R
    - 0x23 or 0x2B → END_MEM
    - 0x04 → DESVIO
    - 0x02 → SALTO
    - 0x08 → EXECUTA_I
    - any other opcode → ILEGAL
- **END_MEM**: `ulaFonteA`=1, `ulaFonteB`=10, ADD. Next state is LE_MEM for 0x23, ESCREVE_MEM for 0x2B.
- **LE_MEM**: `lerMem`=1, `iouD`=1. Waits for `memPronta`, then ESCREVE_LW.
- **ESCREVE_LW**: `escreveReg`=1, `regDst`=0, `memParaReg`=1. Next state BUSCA.
- **ESCREVE_MEM**: `escreveMem`=1, `iouD`=1. Waits for `memPronta`, then BUSCA.
- **EXECUTA_R**
  - Outputs: `ulaFonteA`=1, `ulaFonteB`=00.
  - `controleUla` from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x27 NOR.
  - Unknown funct → ILEGAL; otherwise → FIM_R.
- **FIM_R**: `escreveReg`=1, `regDst`=1, `memParaReg`=0. Next state BUSCA.
- **DESVIO**
  - Outputs: `ulaFonteA`=1, `ulaFonteB`=00, SUB, `fontePC`=01, `escrevePC`=`zero`.
  - Next state BUSCA.
- **SALTO**: `fontePC`=10, `escrevePC`=1. Next state BUSCA.
- **EXECUTA_I**: `ulaFonteA`=1, `ulaFonteB`=10, ADD. Next state FIM_I.
- **FIM_I**: `escreveReg`=1, `regDst`=0, `memParaReg`=0. Next state BUSCA.
- **ILEGAL**: `excecao`=1 for one cycle, no writes. Next state BUSCA; the PC has already advanced, so the instruction is skipped.

## Timing
- State register is updated on the rising clock edge and asynchronously reset to BUSCA.
- While `reset`=1, all outputs are 0, including `lerMem`, and `estado`=0.
- The first memory request is issued in the cycle after `reset` deasserts.
- Outputs are decoded combinationally from state. Only `escrevePC`/`escreveIR` (qualified by `memPronta` or `zero`) and `controleUla` in EXECUTA_R (from `funct`) depend on inputs.
- Cycles per instruction with zero-wait memory: R 4, lw 5, sw 4, beq 3, j 3, addi 4. Each wait cycle (`memPronta`=0) adds 1.
- `memPronta` asserted outside BUSCA, LE_MEM and ESCREVE_MEM is ignored.
- Reset asserted mid-instruction aborts it immediately. No partial `escreveReg` or `escreveMem` is issued after reset asserts.

## Structure
- Shared header `constantes_controle.vh` holds state codes, opcode and funct values, ALU control codes, and `ulaFonteB`/`fontePC` encodings; included by this block and the datapath.
- Sub-module `controle_ula`: combinational (2-bit ulaOp, funct) → (`controleUla`, funct-illegal flag). The FSM drives ulaOp as 00 ADD, 01 SUB, 10 funct-decoded.

## Test plan
- Reset held 3 cycles, `memPronta`=1, opcode 0x00 funct 0x22 → all outputs 0 during reset; then `estado` 0,1,6,7,0; `controleUla`=0011 in EXECUTA_R; `escreveReg`=1 with `regDst`=1 only in FIM_R.
- lw (0x23) with `memPronta` low 2 cycles in LE_MEM → LE_MEM lasts 3 cycles with `lerMem`=`iouD`=1; `escreveReg`+`memParaReg` pulse once; 7 cycles total.
- beq (0x04) with `zero`=1, then with `zero`=0 → `escrevePC`=1 and `fontePC`=01 in DESVIO, then `escrevePC`=0; both take 3 cycles.
- Opcode 0x3F, then R-type funct 0x01 → `estado` reaches 12; `excecao` pulses exactly 1 cycle; no `escreveReg`/`escreveMem`; back to BUSCA.
- sw (0x2B) with `reset` asserted in ESCREVE_MEM while `memPronta`=0 → `escreveMem` drops the same cycle; `estado`=0 asynchronously.
- j (0x02) then addi (0x08) back-to-back → `fontePC`=10, `escrevePC`=1 in SALTO; addi `controleUla`=0010 and `ulaFonteB`=10 in EXECUTA_I, `escreveReg`=1 with `regDst`=0 in FIM_I.

Source files
------------

// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit and its datapath.
package unidade_controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    StBusca      = 4'd0,
    StDecodifica = 4'd1,
    StEndMem     = 4'd2,
    StLeMem      = 4'd3,
    StEscreveLw  = 4'd4,
    StEscreveMem = 4'd5,
    StExecutaR   = 4'd6,
    StFimR       = 4'd7,
    StDesvio     = 4'd8,
    StSalto      = 4'd9,
    StExecutaI   = 4'd10,
    StFimI       = 4'd11,
    StIlegal     = 4'd12
  } estado_t;

  // ALU operation class requested by the FSM
  typedef enum logic [1:0] {
    UlaOpAdd   = 2'b00,
    UlaOpSub   = 2'b01,
    UlaOpFunct = 2'b10
  } ula_op_t;

  localparam logic [5:0] OpTipoR = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpAddi  = 6'h08;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;
  localparam logic [5:0] FnNor = 6'h27;

  localparam logic [3:0] UlaAnd = 4'b0000;
  localparam logic [3:0] UlaOr  = 4'b0001;
  localparam logic [3:0] UlaAdd = 4'b0010;
  localparam logic [3:0] UlaSub = 4'b0011;
  localparam logic [3:0] UlaSlt = 4'b0100;
  localparam logic [3:0] UlaNor = 4'b0101;

  localparam logic [1:0] FonteBReg     = 2'b00;
  localparam logic [1:0] FonteB4       = 2'b01;
  localparam logic [1:0] FonteBImm     = 2'b10;
  localparam logic [1:0] FonteBImmDesl = 2'b11;

  localparam logic [1:0] PcUla    = 2'b00;
  localparam logic [1:0] PcUlaOut = 2'b01;
  localparam logic [1:0] PcSalto  = 2'b10;

endpackage

// File: rtl/unidade_controle_multiciclo_controle_ula.sv
// ALU control decoder: maps the FSM's operation class and funct to a 4-bit ALU code.
module unidade_controle_multiciclo_controle_ula
  import unidade_controle_multiciclo_pkg::*;
(
  input  ula_op_t    ula_op,
  input  logic [5:0] funct,
  output logic [3:0] controle,
  output logic       funct_ilegal
);

  // Decode ALU code; funct is only meaningful for the funct-decoded class
  always_comb begin
    controle     = UlaAdd;
    funct_ilegal = 1'b0;
    unique case (ula_op)
      UlaOpAdd: controle = UlaAdd;
      UlaOpSub: controle = UlaSub;
      UlaOpFunct: begin
        unique case (funct)
          FnAdd:   controle = UlaAdd;
          FnSub:   controle = UlaSub;
          FnAnd:   controle = UlaAnd;
          FnOr:    controle = UlaOr;
          FnSlt:   controle = UlaSlt;
          FnNor:   controle = UlaNor;
          default: funct_ilegal = 1'b1;
        endcase
      end
      default: controle = UlaAdd;
    endcase
  end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath enable.
module unidade_controle_multiciclo
  import unidade_controle_multiciclo_pkg::*;
#(
  parameter int unsigned LARGURA_ESTADO = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  input  logic                      zero,
  input  logic                      memPronta,
  output logic [3:0]                controleUla,
  output logic                      escrevePC,
  output logic                      lerMem,
  output logic                      escreveMem,
  output logic                      iouD,
  output logic                      escreveIR,
  output logic                      regDst,
  output logic                      memParaReg,
  output logic                      escreveReg,
  output logic                      ulaFonteA,
  output logic [1:0]                ulaFonteB,
  output logic [1:0]                fontePC,
  output logic                      excecao,
  output logic [LARGURA_ESTADO-1:0] estado
);

  estado_t    estado_q, estado_d;
  ula_op_t    ula_op;
  logic [3:0] ula_controle;
  logic       funct_ilegal;

  unidade_controle_multiciclo_controle_ula u_controle_ula (
    .ula_op       (ula_op),
    .funct        (funct),
    .controle     (ula_controle),
    .funct_ilegal (funct_ilegal)
  );

  // State register, asynchronously returned to fetch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= StBusca;
    end else begin
      estado_q <= estado_d;
    end
  end

  // ALU operation class per state; kept separate so the decoder result feeds the FSM cleanly
  always_comb begin
    ula_op = UlaOpAdd;
    unique case (estado_q)
      StExecutaR: ula_op = UlaOpFunct;
      StDesvio:   ula_op = UlaOpSub;
      default:    ula_op = UlaOpAdd;
    endcase
  end

  // Next state and outputs; everything forced low while reset is held
  always_comb begin
    estado_d    = estado_q;
    controleUla = 4'b0000;
    escrevePC   = 1'b0;
    lerMem      = 1'b0;
    escreveMem  = 1'b0;
    iouD        = 1'b0;
    escreveIR   = 1'b0;
    regDst      = 1'b0;
    memParaReg  = 1'b0;
    escreveReg  = 1'b0;
    ulaFonteA   = 1'b0;
    ulaFonteB   = FonteBReg;
    fontePC     = PcUla;
    excecao     = 1'b0;
    if (!reset) begin
      unique case (estado_q)
        StBusca: begin
          lerMem      = 1'b1;
          ulaFonteB   = FonteB4;
          controleUla = ula_controle;
          escreveIR   = memPronta;
          escrevePC   = memPronta;
          if (memPronta) estado_d = StDecodifica;
        end
        StDecodifica: begin
          ulaFonteB   = FonteBImmDesl;
          controleUla = ula_controle;
          unique case (opcode)
            OpTipoR:    estado_d = StExecutaR;
            OpLw, OpSw: estado_d = StEndMem;
            OpBeq:      estado_d = StDesvio;
            OpJ:        estado_d = StSalto;
            OpAddi:     estado_d = StExecutaI;
            default:    estado_d = StIlegal;
          endcase
        end
        StEndMem: begin
          ulaFonteA   = 1'b1;
          ulaFonteB   = FonteBImm;
          controleUla = ula_controle;
          estado_d    = (opcode == OpLw) ? StLeMem : StEscreveMem;
        end
        StLeMem: begin
          lerMem = 1'b1;
          iouD   = 1'b1;
          if (memPronta) estado_d = StEscreveLw;
        end
        StEscreveLw: begin
          escreveReg = 1'b1;
          memParaReg = 1'b1;
          estado_d   = StBusca;
        end
        StEscreveMem: begin
          escreveMem = 1'b1;
          iouD       = 1'b1;
          if (memPronta) estado_d = StBusca;
        end
        StExecutaR: begin
          ulaFonteA   = 1'b1;
          controleUla = ula_controle;
          estado_d    = funct_ilegal ? StIlegal : StFimR;
        end
        StFimR: begin
          escreveReg = 1'b1;
          regDst     = 1'b1;
          estado_d   = StBusca;
        end
        StDesvio: begin
          ulaFonteA   = 1'b1;
          controleUla = ula_controle;
          fontePC     = PcUlaOut;
          escrevePC   = zero;
          estado_d    = StBusca;
        end
        StSalto: begin
          fontePC   = PcSalto;
          escrevePC = 1'b1;
          estado_d  = StBusca;
        end
        StExecutaI: begin
          ulaFonteA   = 1'b1;
          ulaFonteB   = FonteBImm;
          controleUla = ula_controle;
          estado_d    = StFimI;
        end
        StFimI: begin
          escreveReg = 1'b1;
          estado_d   = StBusca;
        end
        StIlegal: begin
          // PC already advanced in fetch, so the bad instruction is simply skipped
          excecao  = 1'b1;
          estado_d = StBusca;
        end
        default: estado_d = StBusca;
      endcase
    end
  end

  assign estado = LARGURA_ESTADO'(estado_q);

endmodule
